// File: rtl/binary_mul_share_arb_if.sv
// Requester/response bundle for binary_mul_share_arb.
//
// Purpose: groups the two request channels and the shared response channel
// between the client blocks (master) and the multiplier arbiter (slave).
//
// Signals:
//   req0_valid/req0_a/req0_b  master -> slave  requester 0 operation
//   req0_ready                slave  -> master requester 0 accepted this cycle
//   req1_*                    same, requester 1
//   rsp0_valid/rsp1_valid     slave  -> master result present for requester 0/1
//   rsp_p                     slave  -> master product, shared by both channels
//   rsp_ready                 master -> slave  response consumed
interface binary_mul_share_arb_if #(
  parameter int unsigned W_AB = 3,
  parameter int unsigned W_P  = 5
);
  logic            req0_valid;
  logic [W_AB-1:0] req0_a;
  logic [W_AB-1:0] req0_b;
  logic            req0_ready;
  logic            req1_valid;
  logic [W_AB-1:0] req1_a;
  logic [W_AB-1:0] req1_b;
  logic            req1_ready;
  logic            rsp0_valid;
  logic            rsp1_valid;
  logic [W_P-1:0]  rsp_p;
  logic            rsp_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_p
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_p
  );
endinterface

// File: rtl/binary_mul_share_arb.sv
// Shares one pipelined signed array multiplier between two requesters.
//
// Purpose: arbitrates between two requesters, drives the multiplier operands from
// registers held stable for the whole LATENCY window, captures the product and
// returns it on the winner's response channel.
//
// Ports:
//   clk     clock, all state on rising edge
//   rst     asynchronous, active-high reset
//   bus     binary_mul_share_arb_if.slave: request channels 0/1, shared response
//   mul_a   registered operand A to multiplier
//   mul_b   registered operand B to multiplier
//   mul_en  high while an operation is in flight
//   mul_p   multiplier product
//
// Configuration: define MUL_ARB_FIXED_PRIO_EN to make requester 0 win every
// contention (no round-robin pointer). Default build is round-robin.
module binary_mul_share_arb #(
  parameter int unsigned W_AB    = 3,
  parameter int unsigned W_P     = 5,
  parameter int unsigned LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  binary_mul_share_arb_if.slave bus,
  output logic [W_AB-1:0]       mul_a,
  output logic [W_AB-1:0]       mul_b,
  output logic                  mul_en,
  input  logic [W_P-1:0]        mul_p
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W_AB-1:0] mul_a_q, mul_a_d;
  logic [W_AB-1:0] mul_b_q, mul_b_d;
  logic            owner_q, owner_d;
  logic [W_P-1:0]  rsp_p_q, rsp_p_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;

  logic accept;
  logic grant;  // 1: requester 1 wins, 0: requester 0 wins

  // Readies are forced low during reset so nothing is accepted while rst is high.
  assign accept = (state_q == StIdle) & ~rst & (bus.req0_valid | bus.req1_valid);

`ifdef MUL_ARB_FIXED_PRIO_EN
  // Requester 0 wins any contention.
  assign grant = bus.req1_valid & ~bus.req0_valid;
`else
  logic rr_ptr_q, rr_ptr_d;

  // Contention resolved by rr_ptr; a lone valid always wins.
  assign grant = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    owner_d      = owner_q;
    rsp_p_d      = rsp_p_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mul_a_d = grant ? bus.req1_a : bus.req0_a;
          mul_b_d = grant ? bus.req1_b : bus.req0_b;
          owner_d = grant;
          cnt_d   = CNT_INIT;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Operands have been stable for LATENCY edges once cnt reaches zero.
        if (cnt_q == '0) begin
          rsp_p_d      = mul_p;
          rsp0_valid_d = ~owner_q;
          rsp1_valid_d = owner_q;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      owner_q      <= 1'b0;
      rsp_p_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      owner_q      <= owner_d;
      rsp_p_q      <= rsp_p_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign mul_en         = (state_q == StBusy);
  assign bus.rsp_p      = rsp_p_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;

endmodule
